wave_analyzer: RTL and testbench

WAVE_ANALYZER -- requirements
Module: wave_analyzer

---
 rtl/wave_pkg.sv | 24 ++
 rtl/wave_analyzer_if.sv | 28 ++
 rtl/wave_predictor.sv | 26 ++
 rtl/wave_analyzer.sv | 116 +++++++++++
 tb/tb_wave_analyzer.sv | 138 +++++++++++++
 5 files changed

// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared state type and waveform constants for the triangle-wave analyzer
package wave_pkg;

    typedef enum logic [1:0] {
        ACQ  = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } wave_state_t;

    localparam int WIDTH_DEF = 5;
    localparam int CW_DEF    = 8;

    function automatic int maxv_of(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic int period_of(input int w);
        return 1 << (w + 1);
    endfunction

    localparam int MAXV       = maxv_of(WIDTH_DEF);
    localparam int EXP_PERIOD = period_of(WIDTH_DEF);

endpackage

// File: rtl/wave_analyzer_if.sv
// rtl/wave_analyzer_if.sv - sample input and status outputs of the wave analyzer
interface wave_analyzer_if
    import wave_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = CW_DEF
);
    logic [WIDTH-1:0] wave_in;
    logic             valid_in;
    logic             locked;
    logic             dir;
    logic             peak_pulse;
    logic             trough_pulse;
    logic [CW-1:0]    period;
    logic             period_valid;
    logic             err_pulse;
    logic [CW-1:0]    err_count;

    modport master (
        output wave_in, valid_in,
        input  locked, dir, peak_pulse, trough_pulse, period, period_valid, err_pulse, err_count
    );

    modport slave (
        input  wave_in, valid_in,
        output locked, dir, peak_pulse, trough_pulse, period, period_valid, err_pulse, err_count
    );
endinterface

// File: rtl/wave_predictor.sv
// rtl/wave_predictor.sv - next expected sample from the previous sample and direction
module wave_predictor
    import wave_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] prev,
    input  logic             dir,
    output logic [WIDTH-1:0] expected,
    output logic             turn
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(maxv_of(WIDTH));

    // At an extreme the same value repeats once, so the turn never predicts a wrapped value.
    always_comb begin
        expected = prev;
        turn     = 1'b0;
        if (!dir) begin
            if (prev == MAX_VAL) turn = 1'b1;
            else                 expected = prev + WIDTH'(1);
        end else begin
            if (prev == '0) turn = 1'b1;
            else            expected = prev - WIDTH'(1);
        end
    end
endmodule

// File: rtl/wave_analyzer.sv
// rtl/wave_analyzer.sv - locks onto a triangle wave, reports peaks, troughs, period and mismatches
module wave_analyzer
    import wave_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    wave_analyzer_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(maxv_of(WIDTH));
    localparam logic [CW-1:0]    CNT_MAX = '1;

    wave_state_t      state;
    logic [WIDTH-1:0] prev;
    logic             have_prev;
    logic             have_trough;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] expected;
    logic             turn;

    logic             locked, dir, peak_pulse, trough_pulse, period_valid, err_pulse;
    logic [CW-1:0]    period, err_count;

    wave_predictor #(.WIDTH(WIDTH)) u_pred (
        .prev     (prev),
        .dir      (state == DOWN),
        .expected (expected),
        .turn     (turn)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ACQ;
            prev         <= '0;
            have_prev    <= 1'b0;
            have_trough  <= 1'b0;
            cnt          <= '0;
            locked       <= 1'b0;
            dir          <= 1'b0;
            peak_pulse   <= 1'b0;
            trough_pulse <= 1'b0;
            period_valid <= 1'b0;
            err_pulse    <= 1'b0;
            period       <= '0;
            err_count    <= '0;
        end else begin
            peak_pulse   <= 1'b0;
            trough_pulse <= 1'b0;
            period_valid <= 1'b0;
            err_pulse    <= 1'b0;
            if (bus.valid_in) begin
                prev      <= bus.wave_in;
                have_prev <= 1'b1;
                cnt       <= (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
                case (state)
                    ACQ: begin
                        if (have_prev && bus.wave_in == prev && bus.wave_in == '0) begin
                            state        <= UP;
                            locked       <= 1'b1;
                            dir          <= 1'b0;
                            trough_pulse <= 1'b1;
                            cnt          <= CW'(1);
                            have_trough  <= 1'b1;
                        end else if (have_prev && bus.wave_in == prev && bus.wave_in == MAX_VAL) begin
                            state      <= DOWN;
                            locked     <= 1'b1;
                            dir        <= 1'b1;
                            peak_pulse <= 1'b1;
                        end
                    end
                    UP, DOWN: begin
                        if (bus.wave_in != expected) begin
                            state       <= ACQ;
                            locked      <= 1'b0;
                            dir         <= 1'b0;
                            err_pulse   <= 1'b1;
                            have_trough <= 1'b0;
                            err_count   <= (err_count == CNT_MAX) ? err_count : err_count + CW'(1);
                        end else if (turn && state == UP) begin
                            state      <= DOWN;
                            dir        <= 1'b1;
                            peak_pulse <= 1'b1;
                        end else if (turn) begin
                            // Only a trough reached while already tracking closes a full period.
                            state        <= UP;
                            dir          <= 1'b0;
                            trough_pulse <= 1'b1;
                            cnt          <= CW'(1);
                            have_trough  <= 1'b1;
                            if (have_trough) begin
                                period       <= cnt;
                                period_valid <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= ACQ;
                        locked <= 1'b0;
                        dir    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked       = locked;
    assign bus.dir          = dir;
    assign bus.peak_pulse   = peak_pulse;
    assign bus.trough_pulse = trough_pulse;
    assign bus.period       = period;
    assign bus.period_valid = period_valid;
    assign bus.err_pulse    = err_pulse;
    assign bus.err_count    = err_count;
endmodule

// File: tb/tb_wave_analyzer.sv
// tb/tb_wave_analyzer.sv - directed self-checking bench for wave_analyzer
module tb_wave_analyzer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    wave_analyzer_if bus ();

    wave_analyzer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference generator: index 0 is the first of the two trough zeros.
    function automatic int gen(input int k);
        int p;
        p = k % 64;
        if (p < 2)   return 0;
        if (p <= 33) return (p - 1 > 31) ? 31 : p - 1;
        return 64 - p;
    endfunction

    // {locked, dir, peak, trough, period_valid, err} after sample k, locking at trough sample lock_k.
    function automatic logic [5:0] exp_vec(input int k, input int lock_k);
        int   p;
        logic lk;
        p  = k % 64;
        lk = (k >= lock_k);
        return {lk, lk && (p >= 33 || p == 0), lk && p == 33, lk && p == 1,
                lk && p == 1 && k >= lock_k + 64, 1'b0};
    endfunction

    function automatic logic [5:0] obs_vec();
        return {bus.locked, bus.dir, bus.peak_pulse, bus.trough_pulse, bus.period_valid, bus.err_pulse};
    endfunction

    task automatic step(input int s, input bit v);
        @(negedge clk);
        bus.wave_in  = 5'(s);
        bus.valid_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.wave_in  = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_wave(input string tag, input int start_k, input int n, input int lock_k,
                            input bit gaps, input int exp_period);
        logic [5:0] held;
        for (int k = start_k; k < start_k + n; k++) begin
            if (gaps) begin
                held = (k == start_k) ? 6'b0 : (exp_vec(k - 1, lock_k) & 6'b110000);
                step(7, 1'b0);
                check({tag, "_idle"}, 32'(obs_vec()), 32'(held));
            end
            step(gen(k), 1'b1);
            check(tag, 32'(obs_vec()), 32'(exp_vec(k, lock_k)));
        end
        check({tag, "_period"}, 32'(bus.period), 32'(exp_period));
        check({tag, "_errcnt"}, 32'(bus.err_count), 32'd0);
    endtask

    initial begin
        bus.wave_in  = '0;
        bus.valid_in = 1'b0;
        #1;
        check("reset_vec", 32'(obs_vec()), 32'd0);
        check("reset_period", 32'(bus.period), 32'd0);
        check("reset_errcnt", 32'(bus.err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_wave("cont", 0, 131, 1, 1'b0, 64);

        do_reset();
        step(0, 1'b1);
        step(0, 1'b1);
        check("err_trough", 32'(bus.trough_pulse), 32'd1);
        step(1, 1'b1);
        step(2, 1'b1);
        check("err_pre", 32'(obs_vec()), 32'(6'b100000));
        step(7, 1'b1);
        check("err_vec", 32'(obs_vec()), 32'(6'b000001));
        check("err_cnt1", 32'(bus.err_count), 32'd1);
        step(6, 1'b1);
        check("err_once", 32'(bus.err_pulse), 32'd0);

        do_reset();
        run_wave("midfall", 44, 90, 65, 1'b0, 64);

        do_reset();
        run_wave("gaps", 0, 131, 1, 1'b1, 64);

        do_reset();
        run_wave("prerst", 0, 105, 1, 1'b0, 64);
        #2;
        rst = 1'b1;
        #1;
        check("async_vec", 32'(obs_vec()), 32'd0);
        check("async_period", 32'(bus.period), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_wave("relock", 105, 40, 129, 1'b0, 0);

        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(0, 1'b1);
            step(0, 1'b1);
            step(5, 1'b1);
            if (i == 9) check("errcnt_10", 32'(bus.err_count), 32'd10);
            if (i == 255) check("errcnt_256", 32'(bus.err_count), 32'd255);
        end
        check("errcnt_sat", 32'(bus.err_count), 32'd255);
        check("errcnt_lock", 32'(bus.locked), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
